note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Upstream stage of the tone clock divider. Steps through a loadable song memory of note entries and drives the 20-bit `freq` word (Hz) that the divider turns into an audible square wave.
- Times each note in millisecond units derived from the system clock.
- Inserts a silent articulation gap between notes.
- Signals completion, with optional looping.

Parameters:
- BASE_SPEED, 50000000: system clock in Hz; must match the divider's value.
- DEPTH, 32: song memory entries (power of two).
- UNIT_MS, 50: milliseconds per duration count.
- GAP_MS, 10: silent gap after each note, in ms; 0 means no gap.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  begin playback from entry 0 (level sampled each cycle)
- stop  in  1  abort playback
- loop_en  in  1  restart at entry 0 instead of finishing
- wr_en  in  1  song memory write strobe
- wr_addr  in  $clog2(DEPTH)  write address
- wr_data  in  10  {note[9:4], dur[3:0]}
- freq  out  20  frequency to divider in Hz; 0 = silent
- busy  out  1  high while not IDLE
- note_idx  out  $clog2(DEPTH)  entry currently playing
- done  out  1  one-cycle pulse on natural song end

Behaviour:
- Interface: one clock, `clk`. `rst` is asynchronous and active-low: `rst`=0 immediately forces reset.
- Reset values: freq=0, busy=0, note_idx=0, done=0, state=IDLE, all counters 0. Memory contents are not reset.
- ms tick:
  - Free-running counter counts 0..BASE_SPEED/1000-1.
  - Emits a 1-cycle tick at wrap.
  - Cleared on entry to PLAY and GAP.
- States: IDLE, FETCH, PLAY, GAP.
- IDLE:
  - Outputs freq=0, busy=0.
  - start=1 and stop=0 → idx=0, go to FETCH.
- FETCH (1 cycle):
  - Reads entry[idx].
  - dur≠0 → go to PLAY; load remaining = dur*UNIT_MS; freq = note_freq(note); note_idx=idx.
  - dur=0 (end marker):
    - loop_en=1 and idx≠0 → idx=0, go to FETCH.
    - Otherwise → done=1 for 1 cycle, go to IDLE.
  - An end marker at idx 0 always ends playback, even with loop_en=1, so an empty song cannot spin.
- PLAY:
  - Each tick decrements remaining.
  - When remaining reaches 0:
    - GAP_MS≠0 → freq=0, go to GAP with remaining=GAP_MS.
    - GAP_MS=0 → go to FETCH.
- GAP:
  - Each tick decrements remaining.
  - At 0 → idx++, go to FETCH.
  - With GAP_MS=0, idx++ happens on the PLAY→FETCH transition instead.
- Index wrap: if idx wraps past DEPTH-1, the next entry treated is an end marker, with the same loop rules as FETCH.
- freq is registered. It changes exactly on the cycle the state is entered.
- Latency: start high → freq valid 2 cycles later (IDLE→FETCH→PLAY).
- stop:
  - Any non-IDLE state → IDLE next cycle, freq=0, no done pulse.
  - stop has priority over start in the same cycle.
- start while busy is ignored.
- Writes:
  - Accepted in any state.
  - A write to the entry being fetched in the same cycle returns the old data.
  - A write to a future entry takes effect when that entry is fetched.
- note_freq mapping:
  - code 0 = rest → freq 0.
  - codes 1..48 = C2..B5 equal temperament, rounded to integer Hz. Anchors: code 25 = C4 = 262, code 34 = A4 = 440.
  - codes 49..63 = rest (0).
- Rests still consume their duration and gap.
- Width rules: remaining counter is 16 bits, which covers 15*UNIT_MS up to UNIT_MS=4369. The dur*UNIT_MS product is computed at 16 bits.

Optional Feature:
- Macro: `NOTE_SEQ_PAUSE_EN`.
- When defined:
  - Adds input `pause` (1 bit).
  - While pause=1 in PLAY or GAP: tick counter and remaining freeze, freq is forced to 0, busy stays 1.
  - On release, the saved note freq is restored the next cycle and timing resumes where it froze.
  - stop overrides pause.
- When not defined: no `pause` port and no freeze logic.

Decomposition:
- Shared package `tone_pkg` holds:
  - state enum `seq_state_t`;
  - entry field widths: NOTE_W=6, DUR_W=4, FREQ_W=20;
  - the 48-entry frequency constant table;
  - function `note_freq`.
- One sub-module, `song_ram`:
  - DEPTH x 10 register array;
  - one write port;
  - one synchronous read port (read-before-write).

Test Plan:
- Setup for all scenarios: BASE_SPEED=10000 (tick every 10 cycles), UNIT_MS=2, GAP_MS=1.
- Single note: load {34,3},{x,0}; pulse start → freq=440 two cycles later, held 60 cycles, then 0 for 10 cycles; done pulses once; busy falls.
- Sequence order: load {25,1},{34,1},{0,1},{0,0} → freq sequence 262, 0 (gap), 440, 0, 0 (rest), 0; note_idx steps 0, 1, 2.
- Loop: same song with loop_en=1 → after entry 2, freq returns to 262 with no done pulse. Empty song ({x,0} at 0) with loop_en=1 → done pulses and state returns to IDLE.
- Stop and priority: stop mid-PLAY → freq=0 next cycle, no done. start and stop together in IDLE → remains IDLE.
- Async reset: drive rst=0 mid-note, between clock edges → freq=0 and busy=0 immediately. After release, the song memory contents are unchanged.
- Pause (`NOTE_SEQ_PAUSE_EN`): pause for 25 cycles mid-note → freq=0 during the pause. Total note length becomes 60+25 cycles; freq=440 is restored after release.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types, entry field widths and the note-code to frequency table
// used by the tone sequencer and its song memory.
package tone_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} seq_state_t;

    localparam int NOTE_W    = 6;
    localparam int DUR_W     = 4;
    localparam int FREQ_W    = 20;
    localparam int ENTRY_W   = NOTE_W + DUR_W;
    localparam int REM_W     = 16;
    localparam int NUM_NOTES = 48;

    // Equal-temperament C2..B5 rounded to whole Hz; slot 0 holds note code 1.
    localparam logic [FREQ_W-1:0] FREQ_TABLE [NUM_NOTES] = '{
        20'd65,  20'd69,  20'd73,  20'd78,  20'd82,  20'd87,
        20'd92,  20'd98,  20'd104, 20'd110, 20'd117, 20'd123,
        20'd131, 20'd139, 20'd147, 20'd156, 20'd165, 20'd175,
        20'd185, 20'd196, 20'd208, 20'd220, 20'd233, 20'd247,
        20'd262, 20'd277, 20'd294, 20'd311, 20'd330, 20'd349,
        20'd370, 20'd392, 20'd415, 20'd440, 20'd466, 20'd494,
        20'd523, 20'd554, 20'd587, 20'd622, 20'd659, 20'd698,
        20'd740, 20'd784, 20'd831, 20'd880, 20'd932, 20'd988
    };

    // Code 0 and codes above the table are rests.
    function automatic logic [FREQ_W-1:0] note_freq(input logic [NOTE_W-1:0] code);
        logic [NOTE_W-1:0] slot;
        slot = code - NOTE_W'(1);
        if (code == '0 || code > NOTE_W'(NUM_NOTES))
            return '0;
        return FREQ_TABLE[slot];
    endfunction

endpackage

// File: rtl/song_ram.sv
// Song memory: DEPTH entries of {note, dur}, one write port and one
// registered read port that returns the pre-write contents on a collision.
module song_ram
    import tone_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ENTRY_W-1:0]       rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/note_sequencer.sv
// Steps through the song memory and drives the divider's frequency word.
// Optional freeze input enabled with `define NOTE_SEQ_PAUSE_EN.
module note_sequencer
    import tone_pkg::*;
#(
    parameter int BASE_SPEED = 50000000,
    parameter int DEPTH      = 32,
    parameter int UNIT_MS    = 50,
    parameter int GAP_MS     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [9:0]               wr_data,
`ifdef NOTE_SEQ_PAUSE_EN
    input  logic                     pause,
`endif
    output logic [19:0]              freq,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] note_idx,
    output logic                     done
);

    localparam int AW       = $clog2(DEPTH);
    localparam int TICK_DIV = BASE_SPEED / 1000;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [REM_W-1:0] UNIT_LEN = REM_W'(UNIT_MS);
    localparam logic [REM_W-1:0] GAP_LEN  = REM_W'(GAP_MS);
    localparam logic [AW:0]      IDX_ONE  = (AW+1)'(1);

    seq_state_t          state_q, state_d;
    // Extra top bit marks an index that has run past the last entry.
    logic [AW:0]         idx_q, idx_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic [FREQ_W-1:0]   note_f_q, note_f_d;
    logic [AW-1:0]       nidx_q, nidx_d;
    logic                done_q, done_d;
    logic [ENTRY_W-1:0]  rd_data;
    logic [NOTE_W-1:0]   ent_note;
    logic [DUR_W-1:0]    ent_dur;
    logic                tick;
    logic                freeze;
    logic                enter_timed;

`ifdef NOTE_SEQ_PAUSE_EN
    assign freeze = pause && (state_q == PLAY || state_q == GAP);
`else
    assign freeze = 1'b0;
`endif

    assign tick     = (cnt_q == CNT_MAX) && !freeze;
    assign ent_note = rd_data[ENTRY_W-1:DUR_W];
    assign ent_dur  = rd_data[DUR_W-1:0];

    // Read address follows the next index so FETCH sees its entry.
    song_ram #(.DEPTH(DEPTH)) u_song_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_d[AW-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        freq_d      = freq_q;
        note_f_d    = note_f_q;
        nidx_d      = nidx_q;
        done_d      = 1'b0;
        enter_timed = 1'b0;
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            freq_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    freq_d = '0;
                    if (start && !stop) begin
                        idx_d   = '0;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (ent_dur != '0 && !idx_q[AW]) begin
                        state_d     = PLAY;
                        rem_d       = REM_W'(ent_dur) * UNIT_LEN;
                        note_f_d    = note_freq(ent_note);
                        freq_d      = note_freq(ent_note);
                        nidx_d      = idx_q[AW-1:0];
                        enter_timed = 1'b1;
                    end else if (loop_en && idx_q != '0) begin
                        idx_d   = '0;
                        state_d = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        freq_d  = '0;
                        state_d = IDLE;
                    end
                end
                PLAY: begin
                    freq_d = freeze ? '0 : note_f_q;
                    if (tick) begin
                        if (rem_q <= REM_ONE) begin
                            freq_d = '0;
                            if (GAP_MS != 0) begin
                                state_d     = GAP;
                                rem_d       = GAP_LEN;
                                enter_timed = 1'b1;
                            end else begin
                                state_d = FETCH;
                                idx_d   = idx_q + IDX_ONE;
                            end
                        end else begin
                            rem_d = rem_q - REM_ONE;
                        end
                    end
                end
                GAP: begin
                    freq_d = '0;
                    if (tick) begin
                        if (rem_q <= REM_ONE) begin
                            state_d = FETCH;
                            idx_d   = idx_q + IDX_ONE;
                        end else begin
                            rem_d = rem_q - REM_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    freq_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            freq_q  <= '0;
            nidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            freq_q  <= freq_d;
            nidx_q  <= nidx_d;
            done_q  <= done_d;
            if (enter_timed)
                cnt_q <= '0;
            else if (!freeze)
                cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
        end
    end

    // Saved note frequency, restored after a freeze releases.
    always_ff @(posedge clk) begin
        note_f_q <= note_f_d;
    end

    assign freq     = freq_q;
    assign busy     = (state_q != IDLE);
    assign note_idx = nidx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed, table-driven bench for note_sequencer (10 cycles per ms tick,
// 2 ms duration unit, 1 ms gap, 4-entry song memory).
module tb_note_sequencer;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [9:0]    wr_data = '0;
    logic [19:0]   freq;
    logic          busy;
    logic [AW-1:0] note_idx;
    logic          done;
`ifdef NOTE_SEQ_PAUSE_EN
    logic          pause = 1'b0;
`endif

    int cyc = 0;
    int done_cnt = 0;
    int nchk = 0;
    int nerr = 0;
    int c0 = 0;
    int base = 0;

    typedef struct {
        int            off;
        logic          stp;
        logic          pz;
        logic [19:0]   f;
        logic          b;
        logic [AW-1:0] i;
        logic          d;
    } vec_t;

    vec_t vq[$];

    note_sequencer #(
        .BASE_SPEED (10000),
        .DEPTH      (4),
        .UNIT_MS    (2),
        .GAP_MS     (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
`ifdef NOTE_SEQ_PAUSE_EN
        .pause    (pause),
`endif
        .freq     (freq),
        .busy     (busy),
        .note_idx (note_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1)
            done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int off, input logic stp, input logic pz, input int f,
                       input logic b, input int i, input logic d);
        vec_t v;
        v.off = off;
        v.stp = stp;
        v.pz  = pz;
        v.f   = 20'(f);
        v.b   = b;
        v.i   = AW'(i);
        v.d   = d;
        vq.push_back(v);
    endtask

    task automatic wr(input int addr, input int note, input int dur);
        wr_addr = AW'(addr);
        wr_data = {6'(note), 4'(dur)};
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic to_off(input int off);
        while (cyc < c0 + off) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input string tag);
        foreach (vq[k]) begin
            to_off(vq[k].off);
            stop = vq[k].stp;
`ifdef NOTE_SEQ_PAUSE_EN
            pause = vq[k].pz;
`endif
            @(negedge clk);
            chk($sformatf("%s@%0d freq", tag, vq[k].off), 32'(freq), 32'(vq[k].f));
            chk($sformatf("%s@%0d busy", tag, vq[k].off), 32'(busy), 32'(vq[k].b));
            chk($sformatf("%s@%0d note_idx", tag, vq[k].off), 32'(note_idx), 32'(vq[k].i));
            chk($sformatf("%s@%0d done", tag, vq[k].off), 32'(done), 32'(vq[k].d));
        end
        stop = 1'b0;
`ifdef NOTE_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        vq.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset freq", 32'(freq), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset note_idx", 32'(note_idx), 0);
        chk("reset done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single A4 note, three units long
        wr(0, 34, 3);
        wr(1, 0, 0);
        base = done_cnt;
        add(0,  0, 0, 0,   1, 0, 0);
        add(1,  0, 0, 440, 1, 0, 0);
        add(30, 0, 0, 440, 1, 0, 0);
        add(60, 0, 0, 440, 1, 0, 0);
        add(61, 0, 0, 0,   1, 0, 0);
        add(70, 0, 0, 0,   1, 0, 0);
        add(71, 0, 0, 0,   1, 0, 0);
        add(72, 0, 0, 0,   0, 0, 1);
        add(73, 0, 0, 0,   0, 0, 0);
        kick();
        run("single");
        chk("single done count", 32'(done_cnt - base), 1);

        // C4, A4, rest, end
        wr(0, 25, 1);
        wr(1, 34, 1);
        wr(2, 0, 1);
        wr(3, 0, 0);
        base = done_cnt;
        add(0,  0, 0, 0,   1, 0, 0);
        add(1,  0, 0, 262, 1, 0, 0);
        add(20, 0, 0, 262, 1, 0, 0);
        add(21, 0, 0, 0,   1, 0, 0);
        add(31, 0, 0, 0,   1, 0, 0);
        add(32, 0, 0, 440, 1, 1, 0);
        add(51, 0, 0, 440, 1, 1, 0);
        add(52, 0, 0, 0,   1, 1, 0);
        add(63, 0, 0, 0,   1, 2, 0);
        add(82, 0, 0, 0,   1, 2, 0);
        add(93, 0, 0, 0,   1, 2, 0);
        add(94, 0, 0, 0,   0, 2, 1);
        add(95, 0, 0, 0,   0, 2, 0);
        kick();
        run("seq");
        chk("seq done count", 32'(done_cnt - base), 1);

        // Same song looping, then stopped mid-note
        loop_en = 1'b1;
        base = done_cnt;
        add(0,   0, 0, 0,   1, 2, 0);
        add(1,   0, 0, 262, 1, 0, 0);
        add(21,  0, 0, 0,   1, 0, 0);
        add(32,  0, 0, 440, 1, 1, 0);
        add(63,  0, 0, 0,   1, 2, 0);
        add(93,  0, 0, 0,   1, 2, 0);
        add(94,  0, 0, 0,   1, 2, 0);
        add(95,  0, 0, 262, 1, 0, 0);
        add(100, 1, 0, 262, 1, 0, 0);
        add(101, 0, 0, 0,   0, 0, 0);
        add(102, 0, 0, 0,   0, 0, 0);
        kick();
        run("loop");
        chk("loop done count", 32'(done_cnt - base), 0);

        // Empty song with looping enabled must still end
        wr(0, 5, 0);
        base = done_cnt;
        add(0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1);
        add(2, 0, 0, 0, 0, 0, 0);
        kick();
        run("empty");
        chk("empty done count", 32'(done_cnt - base), 1);
        loop_en = 1'b0;

        // start and stop together while idle
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop busy", 32'(busy), 0);
        chk("startstop freq", 32'(freq), 0);
        @(posedge clk);
        #1;
        chk("startstop busy2", 32'(busy), 0);

        // Full memory: index runs past the last entry; table extremes and a high rest code
        wr(0, 1, 1);
        wr(1, 48, 1);
        wr(2, 25, 1);
        wr(3, 49, 1);
        base = done_cnt;
        add(0,   0, 0, 0,   1, 0, 0);
        add(1,   0, 0, 65,  1, 0, 0);
        add(32,  0, 0, 988, 1, 1, 0);
        add(63,  0, 0, 262, 1, 2, 0);
        add(94,  0, 0, 0,   1, 3, 0);
        add(113, 0, 0, 0,   1, 3, 0);
        add(124, 0, 0, 0,   1, 3, 0);
        add(125, 0, 0, 0,   0, 3, 1);
        add(126, 0, 0, 0,   0, 3, 0);
        kick();
        run("wrap");
        chk("wrap done count", 32'(done_cnt - base), 1);

        // Asynchronous reset mid-note, then replay from unchanged memory
        wr(0, 34, 3);
        wr(1, 0, 0);
        kick();
        to_off(30);
        chk("pre-reset freq", 32'(freq), 440);
        #2;
        rst = 1'b0;
        #1;
        chk("async freq", 32'(freq), 0);
        chk("async busy", 32'(busy), 0);
        chk("async note_idx", 32'(note_idx), 0);
        chk("async done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        add(0,  0, 0, 0,   1, 0, 0);
        add(1,  0, 0, 440, 1, 0, 0);
        add(60, 0, 0, 440, 1, 0, 0);
        add(61, 0, 0, 0,   1, 0, 0);
        add(72, 0, 0, 0,   0, 0, 1);
        kick();
        run("replay");

`ifdef NOTE_SEQ_PAUSE_EN
        // 25-cycle freeze in the middle of the note
        base = done_cnt;
        add(0,  0, 0, 0,   1, 0, 0);
        add(1,  0, 0, 440, 1, 0, 0);
        add(20, 0, 1, 440, 1, 0, 0);
        add(21, 0, 1, 0,   1, 0, 0);
        add(45, 0, 0, 0,   1, 0, 0);
        add(46, 0, 0, 440, 1, 0, 0);
        add(85, 0, 0, 440, 1, 0, 0);
        add(86, 0, 0, 0,   1, 0, 0);
        add(96, 0, 0, 0,   1, 0, 0);
        add(97, 0, 0, 0,   0, 0, 1);
        kick();
        run("pause");
        chk("pause done count", 32'(done_cnt - base), 1);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
